// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the 16-point FFT frame controller.
package fft_pkg;

  localparam int N_POINT   = 16;
  localparam int N_SAMPLES = 1024;
  localparam int PIPE_LAT  = 3;
  localparam int CNT_W     = 10;
  localparam int IDX_W     = 6;
  localparam int N_FRAMES  = N_SAMPLES / N_POINT;
  localparam int PT_W      = $clog2(N_POINT);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } fft_state_t;

  // True when the sample about to be accepted closes a frame.
  function automatic logic is_frame_end(input logic [CNT_W-1:0] cnt);
    return cnt[PT_W-1:0] == PT_W'(N_POINT - 1);
  endfunction

endpackage

// File: rtl/fft_tag_delay.sv
// Fixed-depth 1-bit shift line carrying frame-end tags alongside the FFT pipe.
module fft_tag_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tag_in,
  output logic tag_out
);

  logic [DEPTH-1:0] line;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!rst) line <= '0;
        else      line <= tag_in;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (!rst) line <= '0;
        else      line <= {line[DEPTH-2:0], tag_in};
      end
    end
  endgenerate

  assign tag_out = line[DEPTH-1];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Sequencing controller for the 16-point pipelined FFT: gates FIR samples into
// stage0, follows frame boundaries through the pipe and numbers frame results.
module fft_frame_ctrl
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             fir_valid,
  output logic             shift_en,
  output logic             fft_valid,
  output logic [IDX_W-1:0] frame_idx,
  output logic             done,
  output logic             busy,
  output logic             drop_err
);

  fft_state_t       state, next_state;
  logic [CNT_W-1:0] sample_cnt;
  logic [IDX_W-1:0] frame_cnt, frame_cnt_next;
  logic             tag_push, tag_out, drop_set, last_sample;

  assign last_sample    = (sample_cnt == CNT_W'(N_SAMPLES - 1));
  assign tag_push       = shift_en && is_frame_end(sample_cnt);
  assign frame_cnt_next = fft_valid ? frame_cnt + IDX_W'(1) : frame_cnt;
  assign frame_idx      = frame_cnt;

  fft_tag_delay #(
    .DEPTH (PIPE_LAT)
  ) u_tag_delay (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_push),
    .tag_out (tag_out)
  );

  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    drop_set   = 1'b0;
    case (state)
      IDLE: begin
        shift_en = fir_valid;
        if (fir_valid) next_state = RUN;
      end
      RUN: begin
        shift_en = fir_valid;
        if (fir_valid && last_sample) next_state = DRAIN;
      end
      DRAIN: begin
        drop_set = fir_valid;
        // done marks the final frame of the run leaving stage4
        if (done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      frame_cnt  <= '0;
      fft_valid  <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      state     <= next_state;
      frame_cnt <= frame_cnt_next;
      fft_valid <= tag_out;
      done      <= tag_out && (frame_cnt_next == IDX_W'(N_FRAMES - 1));
      busy      <= (next_state != IDLE);
      if (shift_en) sample_cnt <= sample_cnt + CNT_W'(1);
      if (drop_set) drop_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl against an event-queue model of frame timing.
module tb_fft_frame_ctrl;
  import fft_pkg::*;

  logic             clk;
  logic             rst;
  logic             fir_valid;
  logic             shift_en;
  logic             fft_valid;
  logic [IDX_W-1:0] frame_idx;
  logic             done;
  logic             busy;
  logic             drop_err;

  int checks = 0;
  int errors = 0;

  fft_frame_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .fir_valid (fir_valid),
    .shift_en  (shift_en),
    .fft_valid (fft_valid),
    .frame_idx (frame_idx),
    .done      (done),
    .busy      (busy),
    .drop_err  (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (time %0t)", name, actual, expected, $time);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired, got timeout, expected event (time %0t)", name, $time);
  endtask

  // Model: a run is a count of accepted samples; each completed frame schedules
  // a result pulse PIPE_LAT edges after its last sample in a queue of edge numbers.
  int  m_edge = -1;
  bit  m_known = 0;
  int  m_acc = 0;
  int  m_frame = 0;
  int  m_pend[$];
  bit  m_fft = 0, m_done = 0, m_busy = 0, m_drop = 0;
  int  m_run_start = -1;
  bit  m_take;

  always @(posedge clk) begin
    m_edge++;
    if (!rst) begin
      m_known = 1; m_acc = 0; m_frame = 0; m_pend.delete();
      m_fft = 0; m_done = 0; m_busy = 0; m_drop = 0;
    end else if (m_known) begin
      m_take = fir_valid && (m_acc < N_SAMPLES);
      if (fir_valid && m_acc == N_SAMPLES) m_drop = 1;
      if (m_fft) m_frame = (m_frame + 1) % N_FRAMES;
      if (m_done) m_acc = 0;
      if (m_take) begin
        if (m_acc == 0) m_run_start = m_edge;
        m_acc++;
        if (m_acc % N_POINT == 0) m_pend.push_back(m_edge + PIPE_LAT);
      end
      m_fft = (m_pend.size() > 0) && (m_pend[0] == m_edge);
      if (m_fft) void'(m_pend.pop_front());
      m_done = m_fft && (m_frame == N_FRAMES - 1);
      m_busy = (m_acc > 0);
    end
  end

  // Per-run and cumulative statistics gathered from the DUT for literal checks.
  int pulse_total = 0, done_total = 0;
  int run_pulses = 0, run_dones = 0, first_rel = -1, first_idx = -1, done_rel = -1;

  always @(negedge clk) begin
    if (m_known) begin
      if (m_edge == m_run_start) begin
        run_pulses = 0; run_dones = 0; first_rel = -1; first_idx = -1; done_rel = -1;
      end
      checkOutput("shift_en", shift_en, int'(fir_valid && (m_acc < N_SAMPLES)));
      checkOutput("fft_valid", fft_valid, m_fft);
      checkOutput("done", done, m_done);
      checkOutput("busy", busy, m_busy);
      checkOutput("drop_err", drop_err, m_drop);
      if (m_fft) checkOutput("frame_idx", frame_idx, m_frame);
      if (fft_valid) begin
        pulse_total++;
        run_pulses++;
        if (first_rel < 0) begin
          first_rel = m_edge - m_run_start;
          first_idx = frame_idx;
        end
      end
      if (done) begin
        done_total++;
        run_dones++;
        done_rel = m_edge - m_run_start;
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit fv);
    rst       = r;
    fir_valid = fv;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    applyStimulus(1'b1, 1'b0);
  endtask

  // mode 0: continuous, 1: alternating, 2: random gaps
  task automatic runOne(input int mode, input bit overrun);
    int  guard;
    int  drain_n;
    bit  tog;
    bit  fv;
    bit  seen;
    guard = 0;
    tog   = 1'b1;
    while (m_acc < N_SAMPLES && guard < 8 * N_SAMPLES) begin
      case (mode)
        0:       fv = 1'b1;
        1:       begin fv = tog; tog = !tog; end
        default: fv = ($urandom_range(0, 3) != 0);
      endcase
      applyStimulus(1'b1, fv);
      guard++;
    end
    if (guard >= 8 * N_SAMPLES) failTimeout("run_samples");
    drain_n = 0;
    seen    = 1'b0;
    while (!seen && drain_n < 4 * PIPE_LAT + 8) begin
      applyStimulus(1'b1, overrun && (drain_n < PIPE_LAT));
      drain_n++;
      seen = done;
    end
    if (!seen) failTimeout("done_wait");
    applyStimulus(1'b1, 1'b0);
  endtask

  int base;

  initial begin
    rst       = 1'b0;
    fir_valid = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, (i % 2) == 0);
    checkOutput("reset_fft_valid", fft_valid, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_drop_err", drop_err, 0);
    checkOutput("reset_frame_idx", frame_idx, 0);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] continuous run");
    runOne(0, 1'b0);
    checkOutput("cont_first_pulse_edge", first_rel, 18);
    checkOutput("cont_first_idx", first_idx, 0);
    checkOutput("cont_done_edge", done_rel, 1026);
    checkOutput("cont_pulses", run_pulses, 64);
    checkOutput("cont_dones", run_dones, 1);
    checkOutput("cont_busy_end", busy, 0);
    checkOutput("cont_drop_err", drop_err, 0);

    $display("[TB] gapped run");
    doReset();
    runOne(1, 1'b0);
    checkOutput("gap_first_pulse_edge", first_rel, 33);
    checkOutput("gap_done_edge", done_rel, 2049);
    checkOutput("gap_pulses", run_pulses, 64);

    $display("[TB] overrun during drain");
    doReset();
    runOne(0, 1'b1);
    checkOutput("ovr_drop_err", drop_err, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("ovr_drop_sticky", drop_err, 1);
    checkOutput("ovr_busy_idle", busy, 0);
    doReset();
    checkOutput("ovr_drop_cleared", drop_err, 0);

    $display("[TB] reset mid-run");
    base = pulse_total;
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("abort_pulses", pulse_total - base, 2);
    checkOutput("abort_busy", busy, 0);
    runOne(0, 1'b0);
    checkOutput("restart_first_idx", first_idx, 0);
    checkOutput("restart_pulses", run_pulses, 64);

    $display("[TB] back-to-back runs");
    doReset();
    base = pulse_total;
    begin
      int dbase;
      dbase = done_total;
      runOne(0, 1'b0);
      runOne(0, 1'b0);
      checkOutput("b2b_pulses", pulse_total - base, 128);
      checkOutput("b2b_dones", done_total - dbase, 2);
    end
    checkOutput("b2b_second_first_edge", first_rel, 18);

    $display("[TB] randomized runs");
    for (int r = 0; r < 2; r++) begin
      doReset();
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) applyStimulus(1'b1, 1'b0);
      runOne(2, 1'($urandom_range(0, 1)));
      checkOutput("rand_pulses", run_pulses, 64);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
